down_count_timer: RTL and testbench

- Loadable down-counter/timer: the counting-down counterpart to the team's free-running up-counters.
- Firmware or a controller loads a start value and starts it. The block decrements on enabled prescaled ticks and flags terminal count.
- Supports one-shot and auto-reload modes, with a start/busy/done/ack handshake toward the controlling FSM.

---
 rtl/down_count_pkg.sv | 14 +
 rtl/down_count_timer_tick_prescaler.sv | 44 ++++
 rtl/down_count_timer.sv | 116 +++++++++++
 tb/tb_down_count_timer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/down_count_pkg.sv
// Shared types and defaults for the loadable down-counter timer.
// State encoding is fixed so status decode stays stable across builds.
package down_count_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DIV   = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/down_count_timer_tick_prescaler.sv
// Enabled-clock prescaler: one tick every DIV enabled clocks.
// With DIV==1 the tick simply follows en.
module tick_prescaler #(
   parameter int DIV = 1
) (
   input  logic clk1,
   input  logic clr,
   input  logic en,
   input  logic sclr,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick = (DIV == 1) ? en : (en & (cnt_q == LAST));

   // next prescale phase: sync clear wins, wrap on tick
   always_comb begin
      cnt_d = cnt_q;
      if (sclr) begin
         cnt_d = '0;
      end else if (en) begin
         if (tick) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // phase register
   always_ff @(posedge clk1 or posedge clr) begin
      if (clr) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/down_count_timer.sv
// Loadable down-counter with one-shot / auto-reload modes and a
// start/busy/done/ack handshake; tc pulses on each terminal event.
module down_count_timer
   import down_count_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DIV   = DEF_DIV
) (
   input  logic             clk1,
   input  logic             clr,
   input  logic             en,
   input  logic             start,
   input  logic             stop,
   input  logic             auto_reload,
   input  logic [WIDTH-1:0] load_val,
   input  logic             ack,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             tc,
   output logic             done
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] reload_q;
   logic [WIDTH-1:0] reload_d;
   logic             tc_q;
   logic             tc_d;
   logic             tick;
   logic             run_en;
   logic             ps_clr;

   // prescaler only advances while running; held at phase 0 otherwise
   assign run_en = en & (state_q == ST_RUN);
   assign ps_clr = (state_q != ST_RUN) | stop;

   tick_prescaler #(
      .DIV (DIV)
   ) u_pre (
      .clk1 (clk1),
      .clr  (clr),
      .en   (run_en),
      .sclr (ps_clr),
      .tick (tick)
   );

   // next-state, count, reload and terminal-count decode
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      tc_d     = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (tick) begin
               if (count_q > ONE) begin
                  count_d = count_q - ONE;
               end else begin
                  tc_d = 1'b1;
                  if (auto_reload) begin
                     count_d = reload_q;
                  end else begin
                     count_d = '0;
                     state_d = ST_DONE;
                  end
               end
            end
         end
         ST_IDLE, ST_DONE: begin
            if (start) begin
               if (load_val != '0) begin
                  reload_d = load_val;
                  count_d  = load_val;
                  state_d  = ST_RUN;
               end else begin
                  count_d = '0;
                  tc_d    = 1'b1;
                  state_d = ST_DONE;
               end
            end else if (state_q == ST_DONE && ack) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk1 or posedge clr) begin
      if (clr) begin
         state_q  <= ST_IDLE;
         count_q  <= '0;
         reload_q <= '0;
         tc_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         tc_q     <= tc_d;
      end
   end

   assign count = count_q;
   assign tc    = tc_q;
   assign busy  = (state_q == ST_RUN);
   assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_down_count_timer.sv
// Bench for down_count_timer: DIV=1 and DIV=4 instances share stimulus
// and are compared every cycle against a behavioural timer model.
module tb_down_count_timer;

   logic       clk1 = 1'b0;
   logic       clr;
   logic       en;
   logic       start;
   logic       stop;
   logic       auto_reload;
   logic       ack;
   logic [7:0] load_val;

   logic [7:0] count1;
   logic       busy1;
   logic       tc1;
   logic       done1;
   logic [7:0] count4;
   logic       busy4;
   logic       tc4;
   logic       done4;

   int checks   = 0;
   int failures = 0;

   int m_cnt  [2];
   int m_rel  [2];
   int m_pre  [2];
   bit m_busy [2];
   bit m_done [2];
   bit m_tc   [2];
   int divs   [2] = '{1, 4};

   always #5 clk1 = ~clk1;

   down_count_timer #(.WIDTH(8), .DIV(1)) u_dut1 (
      .clk1        (clk1),
      .clr         (clr),
      .en          (en),
      .start       (start),
      .stop        (stop),
      .auto_reload (auto_reload),
      .load_val    (load_val),
      .ack         (ack),
      .count       (count1),
      .busy        (busy1),
      .tc          (tc1),
      .done        (done1)
   );

   down_count_timer #(.WIDTH(8), .DIV(4)) u_dut4 (
      .clk1        (clk1),
      .clr         (clr),
      .en          (en),
      .start       (start),
      .stop        (stop),
      .auto_reload (auto_reload),
      .load_val    (load_val),
      .ack         (ack),
      .count       (count4),
      .busy        (busy4),
      .tc          (tc4),
      .done        (done4)
   );

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 2; i++) begin
         m_cnt[i]  = 0;
         m_rel[i]  = 0;
         m_pre[i]  = 0;
         m_busy[i] = 1'b0;
         m_done[i] = 1'b0;
         m_tc[i]   = 1'b0;
      end
   endtask

   // timer behaviour for one clock edge, from the current inputs
   task automatic model_next();
      for (int i = 0; i < 2; i++) begin
         m_tc[i] = 1'b0;
         if (m_busy[i]) begin
            if (stop) begin
               m_busy[i] = 1'b0;
               m_pre[i]  = 0;
            end else if (en) begin
               m_pre[i]++;
               if (m_pre[i] == divs[i]) begin
                  m_pre[i] = 0;
                  if (m_cnt[i] > 1) begin
                     m_cnt[i]--;
                  end else begin
                     m_tc[i] = 1'b1;
                     if (auto_reload) begin
                        m_cnt[i] = m_rel[i];
                     end else begin
                        m_cnt[i]  = 0;
                        m_busy[i] = 1'b0;
                        m_done[i] = 1'b1;
                     end
                  end
               end
            end
         end else if (start) begin
            m_pre[i] = 0;
            if (load_val == 0) begin
               m_cnt[i]  = 0;
               m_tc[i]   = 1'b1;
               m_done[i] = 1'b1;
            end else begin
               m_cnt[i]  = load_val;
               m_rel[i]  = load_val;
               m_busy[i] = 1'b1;
               m_done[i] = 1'b0;
            end
         end else if (m_done[i] && ack) begin
            m_done[i] = 1'b0;
         end
      end
   endtask

   task automatic compare();
      chk("cnt_d1",  32'(count1), 32'(m_cnt[0]));
      chk("busy_d1", 32'(busy1),  32'(m_busy[0]));
      chk("tc_d1",   32'(tc1),    32'(m_tc[0]));
      chk("done_d1", 32'(done1),  32'(m_done[0]));
      chk("cnt_d4",  32'(count4), 32'(m_cnt[1]));
      chk("busy_d4", 32'(busy4),  32'(m_busy[1]));
      chk("tc_d4",   32'(tc4),    32'(m_tc[1]));
      chk("done_d4", 32'(done4),  32'(m_done[1]));
   endtask

   task automatic step(int n);
      for (int k = 0; k < n; k++) begin
         model_next();
         @(posedge clk1);
         #1;
         compare();
      end
   endtask

   task automatic go_idle();
      start = 1'b0;
      stop  = 1'b1;
      ack   = 1'b1;
      step(1);
      stop  = 1'b0;
      ack   = 1'b0;
   endtask

   task automatic pulse_start(logic [7:0] lv);
      load_val = lv;
      start    = 1'b1;
      step(1);
      start    = 1'b0;
   endtask

   initial begin
      clr         = 1'b1;
      en          = 1'b1;
      start       = 1'b0;
      stop        = 1'b0;
      auto_reload = 1'b0;
      ack         = 1'b0;
      load_val    = 8'd0;
      m_reset();
      #2;
      compare();
      #10;
      clr = 1'b0;
      step(1);

      // one-shot, load 5
      pulse_start(8'd5);
      chk("os_first", 32'(count1), 32'd5);
      step(4);
      chk("os_pre_tc", 32'(tc1), 32'd0);
      step(1);
      chk("os_tc", 32'(tc1), 32'd1);
      chk("os_done", 32'(done1), 32'd1);
      chk("os_cnt0", 32'(count1), 32'd0);
      step(1);
      chk("os_tc_1cyc", 32'(tc1), 32'd0);
      chk("os_sticky", 32'(done1), 32'd1);
      step(3);
      ack = 1'b1;
      step(1);
      ack = 1'b0;
      chk("os_ack", 32'(done1), 32'd0);
      step(12);
      go_idle();

      // auto-reload, load 3
      auto_reload = 1'b1;
      pulse_start(8'd3);
      step(2);
      step(1);
      chk("ar_tc", 32'(tc1), 32'd1);
      chk("ar_reload", 32'(count1), 32'd3);
      step(12);
      auto_reload = 1'b0;
      step(30);
      chk("ar_to_done", 32'(done4), 32'd1);
      go_idle();

      // DIV=4 with en dropped mid-run
      pulse_start(8'd2);
      step(2);
      en = 1'b0;
      step(3);
      en = 1'b1;
      step(8);
      go_idle();

      // zero load and ignored restart while running
      pulse_start(8'd0);
      chk("z_done", 32'(done1), 32'd1);
      chk("z_busy", 32'(busy1), 32'd0);
      step(2);
      go_idle();
      pulse_start(8'd8);
      step(3);
      pulse_start(8'd9);
      chk("rs_ign", 32'(count1), 32'd4);
      step(4);
      go_idle();

      // stop coincident with terminal tick
      pulse_start(8'd2);
      step(1);
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      chk("st_cnt", 32'(count1), 32'd1);
      chk("st_tc", 32'(tc1), 32'd0);
      chk("st_done", 32'(done1), 32'd0);
      step(2);
      go_idle();

      // asynchronous clear mid-count
      pulse_start(8'd6);
      step(2);
      chk("cl_pre", 32'(count1), 32'd4);
      chk("cl_busy", 32'(busy1), 32'd1);
      #2;
      clr = 1'b1;
      #1;
      m_reset();
      compare();
      #1;
      clr = 1'b0;
      pulse_start(8'd2);
      step(2);
      chk("cl_post", 32'(done1), 32'd1);
      go_idle();

      // randomized traffic
      for (int r = 0; r < 800; r++) begin
         start       = ($urandom_range(0, 7) == 0);
         stop        = ($urandom_range(0, 19) == 0);
         ack         = ($urandom_range(0, 3) == 0);
         en          = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) begin
            auto_reload = ~auto_reload;
         end
         if ($urandom_range(0, 31) == 0) begin
            load_val = 8'hff;
         end else begin
            load_val = 8'($urandom_range(0, 7));
         end
         step(1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
